// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button front end.
package button_pkg;

    // Debounce FSM states, one instance per button channel.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    // Defaults for a 100 MHz clock: 10 ms debounce, 300 ms first repeat, 150 ms repeat rate.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 30_000_000;
    localparam int DEF_REPEAT_PERIOD   = 15_000_000;

    // Counter width able to hold max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser followed by a debounce FSM.
// `press` is the combinational acceptance qualifier for the coming edge;
// the consumer registers it so the strobe lines up with `level` rising.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press,
    output logic held
);

    localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // State register, synchroniser and debounce counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Next-state logic: a new level must persist DEBOUNCE_CYCLES synchronised cycles.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign held  = (state_q == PRESSED);

endmodule

// File: rtl/button_conditioner.sv
// Conditions the `up` and `mode` buttons for the game controller:
// debounced levels, a flap strobe with hold-to-repeat, and a mode toggle.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic clr,
    input  logic up_raw,
    input  logic mode_raw,
    output logic up_level,
    output logic up_pulse,
    output logic mode_level,
    output logic mode_flag
);

    localparam int                 RPT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                 RCNT_W     = cnt_width(RPT_MAX);
    localparam logic [RCNT_W-1:0]  DELAY_CNT  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0]  PERIOD_CNT = RCNT_W'(REPEAT_PERIOD);

    logic              up_press, up_held;
    logic              mode_press, unused_mode_held;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              rep_q, rep_d;
    logic              up_pulse_q, up_pulse_d;
    logic              mode_flag_q, mode_flag_d;
    logic [RCNT_W-1:0] rpt_target;
    logic              rpt_fire;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk   (clk),
        .clr   (clr),
        .raw   (up_raw),
        .level (up_level),
        .press (up_press),
        .held  (up_held)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .clr   (clr),
        .raw   (mode_raw),
        .level (mode_level),
        .press (mode_press),
        .held  (unused_mode_held)
    );

    // Repeat counter, strobe and mode toggle registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rcnt_q      <= '0;
            rep_q       <= 1'b0;
            up_pulse_q  <= 1'b0;
            mode_flag_q <= 1'b0;
        end else begin
            rcnt_q      <= rcnt_d;
            rep_q       <= rep_d;
            up_pulse_q  <= up_pulse_d;
            mode_flag_q <= mode_flag_d;
        end
    end

    // Auto-repeat: count while PRESSED, hold while RELEASE_CHK, clear whenever the
    // debounced level is low. The count restarts from zero after each pulse and
    // rep_q switches the target from the initial delay to the repeat period, so
    // the reload never needs a (possibly negative) DELAY-PERIOD offset.
    always_comb begin
        rcnt_d      = rcnt_q;
        rep_d       = rep_q;
        rpt_fire    = 1'b0;
        rpt_target  = rep_q ? PERIOD_CNT : DELAY_CNT;
        if (!up_level || (REPEAT_DELAY == 0)) begin
            rcnt_d = '0;
            rep_d  = 1'b0;
        end else if (up_held) begin
            if (rcnt_q + 1'b1 == rpt_target) begin
                rpt_fire = 1'b1;
                rcnt_d   = '0;
                rep_d    = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        up_pulse_d  = up_press | rpt_fire;
        mode_flag_d = mode_flag_q ^ mode_press;
    end

    assign up_pulse  = up_pulse_q;
    assign mode_flag = mode_flag_q;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioning for the game's two push inputs (`up` flap button, `mode` select). Sits between the board pins and the game controller. Synchronises each raw input, debounces it, and provides the controller with a one-cycle flap pulse (with optional hold-to-repeat) and a debounced, toggling mode flag. This replaces feeding raw pin levels straight into the control logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronised input must stay at a new level before it is accepted (10 ms at 100 MHz); must be ≥ 1.
- `REPEAT_DELAY`, 30_000_000: cycles `up` must be held after acceptance before the first auto-repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 15_000_000: cycles between subsequent auto-repeat pulses; must be ≥ 1.

Ports:
- `clk` in 1: system clock; one clock domain.
- `clr` in 1: reset, asynchronous, active-high.
- `up_raw` in 1: raw flap button pin, asynchronous to `clk`.
- `mode_raw` in 1: raw mode button pin, asynchronous to `clk`.
- `up_level` out 1: debounced `up` level.
- `up_pulse` out 1: one-cycle flap strobe on an accepted press and on each auto-repeat.
- `mode_level` out 1: debounced `mode` level.
- `mode_flag` out 1: toggles on each accepted `mode` press; feeds controller `mode`.

## Operation
- Every output is registered. On reset, all outputs are 0, both channels are in RELEASED, and all counters and synchroniser flops are 0.
- Per channel: 2-flop synchroniser `s1→s2`, then the debounce FSM on `s2`:
  - RELEASED: when `s2`=1, go to PRESS_CHK with cnt=0.
  - PRESS_CHK: if `s2`=0, go to RELEASED with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set level←1, and fire the press event. Else cnt++.
  - PRESSED: when `s2`=0, go to RELEASE_CHK with cnt=0.
  - RELEASE_CHK: if `s2`=1, go to PRESSED with cnt=0 and no event. Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED and set level←0. Else cnt++.
- A press event is a single-cycle registered strobe. It fires only on the PRESS_CHK→PRESSED transition. A PRESSED↔RELEASE_CHK bounce never re-fires it.
- `up` channel auto-repeat (only if REPEAT_DELAY>0):
  - rcnt clears on entry to PRESSED.
  - While in PRESSED, rcnt increments each cycle.
  - A pulse fires when rcnt reaches REPEAT_DELAY; rcnt then reloads so the next pulse fires REPEAT_PERIOD cycles later.
  - rcnt holds in RELEASE_CHK and clears on exit to RELEASED.
- `up_pulse` = press event OR repeat pulse. These cannot coincide, because rcnt clears on the same edge as the press event.
- `mode_flag` ← ~`mode_flag` on each `mode` press event, in the same edge that the strobe is registered.
- Counter widths are $clog2 of the largest compared value, plus 1. Counters never wrap: they saturate by construction because the FSM leaves the state at the terminal count.

## Timing
- Edge 0 is the first edge that samples `raw`=1 into `s1`. `s2`=1 after edge 1, PRESS_CHK is entered at edge 2, and `level`/`pulse` rise at edge 2+DEBOUNCE_CYCLES.
- Release: `level` falls at edge 2+DEBOUNCE_CYCLES after the first edge that samples 0, provided the input stays stable.
- `up_pulse` and the `mode_flag` change are high/visible for exactly one cycle at the same edge `level` rises.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change in either direction.
- `clr` asserted mid-count or mid-hold: all outputs drop to 0 immediately (asynchronously). After `clr` release, a still-held button is treated as a fresh press (full latency, one pulse, and a `mode_flag` toggle to 1).
- Both channels are fully independent. Simultaneous presses on `up` and `mode` produce events in the same cycle.

## Structure
- Package `button_pkg`:
  - the 2-bit FSM state enum (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK);
  - the default debounce/repeat constants for a 100 MHz clock.
- Sub-module `debounce_channel`:
  - contents: synchroniser, FSM, cnt, `level` and `press` outputs;
  - instantiated twice;
  - auto-repeat and the `mode` toggle live in `button_conditioner`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: `up_raw` 0→1 and held 8 cycles → `up_level` rises at edge 6 and `up_pulse`=1 for exactly cycle 6, with no repeat.
- Bounce: `up_raw` toggled 1,0,1,0 every 2 cycles, then held 1 → no output until 4 stable synchronised cycles, then exactly one `up_pulse`. Release bounces of 3 cycles produce no second pulse.
- Auto-repeat: hold `up_raw` 40 cycles → pulses at edges 6, 16, 21, 26, 31, 36, …; release stops them and `up_level` falls 6 edges after release.
- Mode toggle: three separate clean `mode_raw` presses → `mode_flag` goes 1, 0, 1. Holding `mode_raw` never re-toggles it.
- Reset mid-operation: assert `clr` during auto-repeat hold → all outputs 0 within the same cycle. Deassert `clr` with buttons held → fresh press after 6 edges, `mode_flag`=1.
- Simultaneous: `up_raw` and `mode_raw` rise together → `up_pulse` and the `mode_flag` toggle occur on the same edge (6).
